priority_arbiter: RTL and testbench
===================================

// Module: priority_arbiter
// PURPOSE
//  Consumer side of the per-requester priority register array: reads the 8 stored
//  2-bit priorities plus a request vector and issues one registered grant at a time.
//  Highest priority wins; ties resolve round-robin. Grant holds until the owner
//  drops its request or a hold timeout forces release. Sits between the priority
//  register array and the shared resource it protects.
// PARAMETERS
//  NUM_REQ   8   requesters; ID_W = $clog2(NUM_REQ)
//  PRIO_W    2   priority width; larger value = higher priority
//  MAX_HOLD  16  max grant cycles before forced release when others wait; 0 = never
// PORTS
//  clk         in   1                 single clock, rising edge
//  reset       in   1                 asynchronous, active-low; 0 = in reset
//  req         in   NUM_REQ           level request per requester
//  prio_vec    in   NUM_REQ*PRIO_W    requester i priority at [i*PRIO_W +: PRIO_W]
//  gnt_valid   out  1                 grant active
//  gnt_onehot  out  NUM_REQ           one-hot owner; all 0 when !gnt_valid
//  gnt_id      out  ID_W              owner index; 0 when !gnt_valid
//  gnt_prio    out  PRIO_W            owner priority snapshotted at grant time
//  preempted   out  1                 1-cycle pulse when grant ends by timeout
// BEHAVIOUR
//  - Reset (async assert): all outputs 0; state IDLE; hold_cnt 0; rr_last = NUM_REQ-1.
//  - All outputs registered. FSM states IDLE, GRANT.
//  - IDLE: if |req, select winner -> GRANT; gnt_* valid the next cycle (latency 1).
//    Else stay IDLE.
//  - Selection: max prio among set req bits; among ties, first index searching
//    upward (wrapping) from rr_last+1. On grant: rr_last <= winner,
//    gnt_prio <= prio_vec[winner].
//  - GRANT: hold_cnt increments each cycle, saturating at MAX_HOLD-1.
//    * !req[owner]: clear grant next cycle, -> IDLE (one dead cycle before re-arbitration).
//    * else if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and other req bits set: clear grant,
//      pulse preempted, -> IDLE.
//    * else keep grant; with no other requester, hold indefinitely.
//  - Release and timeout in the same cycle: treated as release; preempted stays 0.
//  - prio_vec or non-owner req changes during GRANT do not affect the current owner
//    or gnt_prio. They are used only at the next IDLE selection.
//  - Preempted owner still requesting re-competes normally. rr_last = that owner,
//    so equal-priority peers win first.
//  - hold_cnt clears on entry to IDLE. Width = $clog2(MAX_HOLD) (min 1).
//  - Reset mid-grant: grant drops asynchronously; the next tie starts from index 0.
// STRUCTURE
//  - priority_pkg: PRIO_W, default NUM_REQ, arb_state_t {IDLE, GRANT}.
//  - Sub-module rr_prio_select (combinational): req, prio_vec, rr_last -> winner
//    index and any-valid. Arbiter FSM, counters and output registers stay in
//    priority_arbiter.
// TESTING
//  1. Assert reset=0 with req=8'hFF -> all outputs 0. Release reset -> first grant
//     is to id 0 (all equal priority).
//  2. prio0=1, prio2=3, req=8'h05 -> next cycle gnt_id=2, gnt_onehot=8'h04,
//     gnt_prio=3.
//  3. All prio=2, req=8'hFF, owner drops req 3 cycles after each grant and
//     re-raises -> grant order 0,1,...,7,0, with one idle cycle between grants.
//  4. MAX_HOLD=4: req[1] held, req[3] raised during grant -> grant to 1 lasts
//     4 cycles, preempted pulses, idle cycle, then gnt_id=3.
//  5. req[5] alone for 50 cycles with MAX_HOLD=4 -> grant never drops. Change
//     prio5 mid-grant -> gnt_prio unchanged.
//  6. Drop req[owner] in the same cycle as the timeout -> preempted=0, normal
//     release. Async reset mid-grant -> gnt_valid=0 before the next clk edge.

Source files
------------

// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared constants and types for the priority arbiter
package priority_pkg;

    localparam int PRIO_W      = 2;
    localparam int NUM_REQ_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/priority_arbiter_if.sv
// rtl/priority_arbiter_if.sv - request/priority in, grant out bundle for the arbiter
interface priority_arbiter_if
    import priority_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*PRIO_W-1:0] prio_vec;
    logic                      gnt_valid;
    logic [NUM_REQ-1:0]        gnt_onehot;
    logic [ID_W-1:0]           gnt_id;
    logic [PRIO_W-1:0]         gnt_prio;
    logic                      preempted;

    // requesters plus priority register array side
    modport master (
        output req, prio_vec,
        input  gnt_valid, gnt_onehot, gnt_id, gnt_prio, preempted
    );

    // arbiter side
    modport slave (
        input  req, prio_vec,
        output gnt_valid, gnt_onehot, gnt_id, gnt_prio, preempted
    );

endinterface

// File: rtl/rr_prio_select.sv
// rtl/rr_prio_select.sv - highest-priority winner with round-robin tie break
module rr_prio_select
    import priority_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*PRIO_W-1:0] prio_vec,
    input  logic [ID_W-1:0]           rr_last,
    output logic [ID_W-1:0]           winner,
    output logic                      any_valid
);

    logic [PRIO_W-1:0] max_prio;
    logic              found;
    int                idx;

    // find top priority among requesters, then first match after rr_last
    always_comb begin
        any_valid = |req;
        max_prio  = '0;
        winner    = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (prio_vec[i*PRIO_W +: PRIO_W] > max_prio)) begin
                max_prio = prio_vec[i*PRIO_W +: PRIO_W];
            end
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (!found && req[idx] && (prio_vec[idx*PRIO_W +: PRIO_W] == max_prio)) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - registered priority arbiter with hold timeout
module priority_arbiter
    import priority_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    priority_arbiter_if.slave bus
);

    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_TOP = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HC_W-1:0]    HOLD_LAST  = HC_W'(HOLD_TOP);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0  = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    RR_RESET   = ID_W'(NUM_REQ - 1);

    arb_state_t        state;
    logic [HC_W-1:0]   hold_cnt;
    logic [ID_W-1:0]   rr_last;
    logic              gnt_valid;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]   gnt_id;
    logic [PRIO_W-1:0] gnt_prio;
    logic              preempted;

    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              others_waiting;

    rr_prio_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_select (
        .req       (bus.req),
        .prio_vec  (bus.prio_vec),
        .rr_last   (rr_last),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign others_waiting = |(bus.req & ~gnt_onehot);

    // arbitration FSM with registered grant outputs and hold timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            rr_last    <= RR_RESET;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_id     <= '0;
            gnt_prio   <= '0;
            preempted  <= 1'b0;
        end else begin
            preempted <= 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (any_valid) begin
                        state      <= GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_onehot <= ONE_HOT_0 << winner;
                        gnt_id     <= winner;
                        gnt_prio   <= bus.prio_vec[int'(winner)*PRIO_W +: PRIO_W];
                        rr_last    <= winner;
                    end
                end
                GRANT: begin
                    if (!bus.req[gnt_id]) begin
                        // owner release wins over a coincident timeout
                        state      <= IDLE;
                        hold_cnt   <= '0;
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                        gnt_id     <= '0;
                        gnt_prio   <= '0;
                    end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others_waiting) begin
                        state      <= IDLE;
                        hold_cnt   <= '0;
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                        gnt_id     <= '0;
                        gnt_prio   <= '0;
                        preempted  <= 1'b1;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_valid  = gnt_valid;
    assign bus.gnt_onehot = gnt_onehot;
    assign bus.gnt_id     = gnt_id;
    assign bus.gnt_prio   = gnt_prio;
    assign bus.preempted  = preempted;

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - directed self-checking bench for priority_arbiter
module tb_priority_arbiter;
    import priority_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    priority_arbiter_if #(.NUM_REQ(8)) bus ();

    priority_arbiter #(
        .NUM_REQ  (8),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.prio_vec = '0;
        #1 reset = 1'b0;
        bus.req = 8'hFF;
        repeat (3) @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid got %0h exp 0", bus.gnt_valid); end
        checks++; if (bus.gnt_onehot !== 8'h00) begin errors++; $display("FAIL reset_gnt_onehot got %0h exp 0", bus.gnt_onehot); end
        checks++; if (bus.gnt_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id got %0h exp 0", bus.gnt_id); end
        checks++; if (bus.gnt_prio !== 2'd0) begin errors++; $display("FAIL reset_gnt_prio got %0h exp 0", bus.gnt_prio); end
        checks++; if (bus.preempted !== 1'b0) begin errors++; $display("FAIL reset_preempted got %0h exp 0", bus.preempted); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 3'd0 || bus.gnt_onehot !== 8'h01) begin
            errors++; $display("FAIL first_grant got valid=%0h id=%0d onehot=%0h exp valid=1 id=0 onehot=01", bus.gnt_valid, bus.gnt_id, bus.gnt_onehot);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        bus.prio_vec = 16'h0031;
        bus.req = 8'h05;
        @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %0h exp 1", bus.gnt_valid); end
        checks++; if (bus.gnt_id !== 3'd2) begin errors++; $display("FAIL prio_id got %0d exp 2", bus.gnt_id); end
        checks++; if (bus.gnt_onehot !== 8'h04) begin errors++; $display("FAIL prio_onehot got %0h exp 04", bus.gnt_onehot); end
        checks++; if (bus.gnt_prio !== 2'd3) begin errors++; $display("FAIL prio_gnt_prio got %0d exp 3", bus.gnt_prio); end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int exp_id;
        bus.prio_vec = 16'hAAAA;
        bus.req = 8'hFF;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int g = 0; g < 9; g++) begin
            exp_id = g % 8;
            @(negedge clk);
            checks++; if (bus.gnt_valid !== 1'b1 || int'(bus.gnt_id) != exp_id) begin
                errors++; $display("FAIL rr_grant_%0d got valid=%0h id=%0d exp valid=1 id=%0d", g, bus.gnt_valid, bus.gnt_id, exp_id);
            end
            repeat (2) @(negedge clk);
            bus.req[exp_id] = 1'b0;
            @(negedge clk);
            checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d got %0h exp 0", g, bus.gnt_valid); end
            bus.req[exp_id] = 1'b1;
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int held;
        bus.prio_vec = 16'hAAAA;
        bus.req = 8'h02;
        @(negedge clk);
        held = 0;
        if (bus.gnt_valid === 1'b1 && bus.gnt_id === 3'd1) held++;
        bus.req = 8'h0A;
        repeat (3) begin
            @(negedge clk);
            if (bus.gnt_valid === 1'b1 && bus.gnt_id === 3'd1) held++;
        end
        checks++; if (held != 4) begin errors++; $display("FAIL timeout_hold_len got %0d exp 4", held); end
        @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL timeout_drop got %0h exp 0", bus.gnt_valid); end
        checks++; if (bus.preempted !== 1'b1) begin errors++; $display("FAIL timeout_preempted got %0h exp 1", bus.preempted); end
        @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 3'd3) begin
            errors++; $display("FAIL timeout_next got valid=%0h id=%0d exp valid=1 id=3", bus.gnt_valid, bus.gnt_id);
        end
        checks++; if (bus.preempted !== 1'b0) begin errors++; $display("FAIL timeout_pulse_len got %0h exp 0", bus.preempted); end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold_lone();
        int held;
        int pre_seen;
        bus.prio_vec = 16'hAAAA;
        bus.req = 8'h20;
        held = 0;
        pre_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.gnt_valid === 1'b1 && bus.gnt_id === 3'd5) held++;
            if (bus.preempted !== 1'b0) pre_seen++;
            if (i == 25) bus.prio_vec = 16'hA2AA;
        end
        checks++; if (held != 50) begin errors++; $display("FAIL lone_hold got %0d exp 50", held); end
        checks++; if (pre_seen != 0) begin errors++; $display("FAIL lone_preempt got %0d exp 0", pre_seen); end
        checks++; if (bus.gnt_prio !== 2'd2) begin errors++; $display("FAIL lone_prio_snapshot got %0d exp 2", bus.gnt_prio); end
        bus.req = '0;
        bus.prio_vec = 16'hAAAA;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_release_and_reset();
        bus.req = 8'h02;
        @(negedge clk);
        checks++; if (bus.gnt_id !== 3'd1 || bus.gnt_valid !== 1'b1) begin
            errors++; $display("FAIL rel_grant got valid=%0h id=%0d exp valid=1 id=1", bus.gnt_valid, bus.gnt_id);
        end
        bus.req = 8'h0A;
        repeat (3) @(negedge clk);
        bus.req = 8'h08;
        @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL rel_drop got %0h exp 0", bus.gnt_valid); end
        checks++; if (bus.preempted !== 1'b0) begin errors++; $display("FAIL rel_preempted got %0h exp 0", bus.preempted); end
        @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 3'd3) begin
            errors++; $display("FAIL rel_next got valid=%0h id=%0d exp valid=1 id=3", bus.gnt_valid, bus.gnt_id);
        end
        bus.req = 8'h09;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 8'h00) begin
            errors++; $display("FAIL async_reset got valid=%0h onehot=%0h exp valid=0 onehot=00", bus.gnt_valid, bus.gnt_onehot);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 3'd0) begin
            errors++; $display("FAIL post_reset_tie got valid=%0h id=%0d exp valid=1 id=0", bus.gnt_valid, bus.gnt_id);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_priority();
        test_round_robin();
        test_timeout();
        test_hold_lone();
        test_release_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
